// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int unsigned MDU_LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MDU_BUSY = 2'd2
    } hazardState_t;

    // Bits needed to hold a down-counter starting at the given latency.
    function automatic int unsigned cntWidth(input int unsigned latency);
        return (latency < 2) ? 1 : $clog2(latency + 1);
    endfunction

    localparam int unsigned MDU_CNT_W = cntWidth(MDU_LATENCY_MAX);

endpackage

// File: rtl/hazard_stall_controller_mdu.sv
// MDU occupancy tracker: loads a down-counter on an accepted start and
// reports busy while it is non-zero, plus the final busy cycle.
module mdu_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned Latency = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic busy,
    output logic last
);

    logic [MDU_CNT_W-1:0] cntQ, cntD;

    always_comb begin
        cntD = cntQ;
        if (accept) begin
            cntD = MDU_CNT_W'(Latency);
        end else if (cntQ != '0) begin
            cntD = cntQ - MDU_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign busy = (cntQ != '0);
    assign last = (cntQ == MDU_CNT_W'(1));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: detects load-use, ID-branch and MDU
// hazards, drives PC/IF-ID/ID-EX control and counts stall cycles.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  RsAddress_ID,
    input  logic [REG_ADDR_W-1:0]  RtAddress_ID,
    input  logic                   UsesRt_ID,
    input  logic                   Branch_ID,
    input  logic                   BranchTaken_ID,
    input  logic                   MduStart_ID,
    input  logic                   MduRead_ID,
    input  logic                   RegWrite_EX,
    input  logic                   MemRead_EX,
    input  logic [REG_ADDR_W-1:0]  RdAddress_EX,
    input  logic                   MemRead_MEM,
    input  logic [REG_ADDR_W-1:0]  RdAddress_MEM,
    output logic                   PCWrite,
    output logic                   IF_ID_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Bubble,
    output logic                   MduBusy,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    // Register 0 is hard-wired, so it never produces a dependency.
    function automatic logic regMatch(
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  usesRt
    );
        return (dst != REG_ZERO) && ((dst == rs) || (usesRt && (dst == rt)));
    endfunction

    hazardState_t stateQ, stateD;

    logic matchEx, matchMem;
    logic loadUse, brEx, brMem, mduHz;
    logic active, stall, accept, mduLast;
    logic [STALL_CNT_W-1:0] stallCntQ, stallCntD;

    assign matchEx  = regMatch(RdAddress_EX, RsAddress_ID, RtAddress_ID, UsesRt_ID);
    assign matchMem = regMatch(RdAddress_MEM, RsAddress_ID, RtAddress_ID, UsesRt_ID);

    assign loadUse = MemRead_EX & RegWrite_EX & matchEx;
    assign brEx    = Branch_ID & RegWrite_EX & matchEx;
    assign brMem   = Branch_ID & MemRead_MEM & matchMem;
    assign mduHz   = MduBusy & (MduRead_ID | MduStart_ID);

    assign active = (stateQ != HOLD);
    assign stall  = active & (loadUse | brEx | brMem | mduHz);

    // A start paired with a branch is an illegal encoding and is dropped.
    assign accept = (stateQ == RUN) & MduStart_ID & ~stall & ~Branch_ID;

    mdu_busy_tracker #(
        .Latency(MDU_LATENCY)
    ) u_mdu_busy_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .accept(accept),
        .busy  (MduBusy),
        .last  (mduLast)
    );

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            HOLD:     stateD = RUN;
            RUN:      if (accept) stateD = MDU_BUSY;
            MDU_BUSY: if (mduLast) stateD = RUN;
            default:  stateD = HOLD;
        endcase
    end

    // Stall wins over a taken-branch flush; the branch re-resolves next cycle.
    always_comb begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        IF_ID_Flush  = 1'b0;
        if (active && !stall) begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
            ID_EX_Bubble = 1'b0;
            IF_ID_Flush  = Branch_ID & BranchTaken_ID;
        end
    end

    always_comb begin
        stallCntD = stallCntQ;
        if (stall && (stallCntQ != '1)) begin
            stallCntD = stallCntQ + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= HOLD;
            stallCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            stallCntQ <= stallCntD;
        end
    end

    assign StallCycles = stallCntQ;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural reference model.
module tb_hazard_stall_controller;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 16;
    localparam int          SAT = 65535;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    RsAddress_ID, RtAddress_ID, RdAddress_EX, RdAddress_MEM;
    logic          UsesRt_ID, Branch_ID, BranchTaken_ID, MduStart_ID, MduRead_ID;
    logic          RegWrite_EX, MemRead_EX, MemRead_MEM;
    logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MduBusy;
    logic [CW-1:0] StallCycles;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: in-hold flag, remaining busy cycles, stall count.
    bit mHold     = 1'b1;
    int mBusyLeft = 0;
    int mStallCnt = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MDU_LATENCY(LAT),
        .STALL_CNT_W(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RsAddress_ID  (RsAddress_ID),
        .RtAddress_ID  (RtAddress_ID),
        .UsesRt_ID     (UsesRt_ID),
        .Branch_ID     (Branch_ID),
        .BranchTaken_ID(BranchTaken_ID),
        .MduStart_ID   (MduStart_ID),
        .MduRead_ID    (MduRead_ID),
        .RegWrite_EX   (RegWrite_EX),
        .MemRead_EX    (MemRead_EX),
        .RdAddress_EX  (RdAddress_EX),
        .MemRead_MEM   (MemRead_MEM),
        .RdAddress_MEM (RdAddress_MEM),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Bubble  (ID_EX_Bubble),
        .MduBusy       (MduBusy),
        .StallCycles   (StallCycles)
    );

    function automatic bit depends(input logic [4:0] dst);
        if (dst == 5'd0) return 1'b0;
        return (dst == RsAddress_ID) || (UsesRt_ID && dst == RtAddress_ID);
    endfunction

    function automatic bit refStall();
        bit busy;
        if (mHold || !rst_n) return 1'b0;
        busy = (mBusyLeft > 0);
        return (MemRead_EX && RegWrite_EX && depends(RdAddress_EX))
            || (Branch_ID && RegWrite_EX && depends(RdAddress_EX))
            || (Branch_ID && MemRead_MEM && depends(RdAddress_MEM))
            || (busy && (MduRead_ID || MduStart_ID));
    endfunction

    // Packed {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MduBusy}.
    function automatic logic [4:0] refOutputs();
        bit busy;
        busy = (mBusyLeft > 0);
        if (mHold || !rst_n) return {1'b0, 1'b0, 1'b0, 1'b1, busy};
        if (refStall()) return {1'b0, 1'b0, 1'b0, 1'b1, busy};
        return {1'b1, 1'b1, (Branch_ID && BranchTaken_ID), 1'b0, busy};
    endfunction

    task automatic idleInputs();
        RsAddress_ID = 5'd0; RtAddress_ID = 5'd0; RdAddress_EX = 5'd0; RdAddress_MEM = 5'd0;
        UsesRt_ID = 1'b0; Branch_ID = 1'b0; BranchTaken_ID = 1'b0; MduStart_ID = 1'b0;
        MduRead_ID = 1'b0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0; MemRead_MEM = 1'b0;
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        bit s;
        s = refStall();
        @(posedge clk);
        if (!rst_n) begin
            mHold = 1'b1; mBusyLeft = 0; mStallCnt = 0;
        end else if (mHold) begin
            mHold = 1'b0;
        end else begin
            if (s && mStallCnt < SAT) mStallCnt++;
            if (mBusyLeft > 0) mBusyLeft--;
            else if (MduStart_ID && !s && !Branch_ID) mBusyLeft = LAT;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleInputs();
        tick();
        tick();
        #3;
        nChecks++;
        if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MduBusy} !== 5'b00010
            || StallCycles !== 16'd0) begin
            nFails++;
            $display("FAIL reset_outputs: got ctl=%b cnt=%0d want ctl=00010 cnt=0",
                     {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MduBusy}, StallCycles);
        end
        rst_n = 1'b1;
        #1;
        nChecks++;
        if (PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1) begin
            nFails++;
            $display("FAIL hold_cycle: got PCWrite=%b Bubble=%b want 0/1", PCWrite, ID_EX_Bubble);
        end
        tick();
        #3;
        nChecks++;
        if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1 || ID_EX_Bubble !== 1'b0
            || StallCycles !== 16'd0) begin
            nFails++;
            $display("FAIL first_run: got PCWrite=%b IFID=%b Bubble=%b cnt=%0d want 1/1/0/0",
                     PCWrite, IF_ID_Write, ID_EX_Bubble, StallCycles);
        end
    endtask

    task automatic test_load_use();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; RdAddress_EX = 5'd8; RsAddress_ID = 5'd8;
        #3;
        nChecks++;
        if (PCWrite !== 1'b0 || IF_ID_Write !== 1'b0 || ID_EX_Bubble !== 1'b1) begin
            nFails++;
            $display("FAIL load_use_stall: got PCWrite=%b IFID=%b Bubble=%b want 0/0/1",
                     PCWrite, IF_ID_Write, ID_EX_Bubble);
        end
        tick();
        MemRead_EX = 1'b0; RegWrite_EX = 1'b0;
        #3;
        nChecks++;
        if (StallCycles !== 16'd1 || PCWrite !== 1'b1) begin
            nFails++;
            $display("FAIL load_use_count: got cnt=%0d PCWrite=%b want 1/1", StallCycles, PCWrite);
        end
        tick();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; RdAddress_EX = 5'd0; RsAddress_ID = 5'd0;
        UsesRt_ID = 1'b1; RtAddress_ID = 5'd0;
        #3;
        nChecks++;
        if (PCWrite !== 1'b1 || ID_EX_Bubble !== 1'b0) begin
            nFails++;
            $display("FAIL load_use_r0: got PCWrite=%b Bubble=%b want 1/0", PCWrite, ID_EX_Bubble);
        end
        RdAddress_EX = 5'd12; RtAddress_ID = 5'd12;
        #1;
        nChecks++;
        if (PCWrite !== 1'b0) begin
            nFails++;
            $display("FAIL load_use_rt: got PCWrite=%b want 0", PCWrite);
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_branch();
        int base;
        base = mStallCnt;
        Branch_ID = 1'b1; RsAddress_ID = 5'd9; RegWrite_EX = 1'b1; RdAddress_EX = 5'd9;
        #3;
        nChecks++;
        if (PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1) begin
            nFails++;
            $display("FAIL branch_ex: got PCWrite=%b Bubble=%b want 0/1", PCWrite, ID_EX_Bubble);
        end
        tick();
        RegWrite_EX = 1'b0; RdAddress_EX = 5'd0; MemRead_MEM = 1'b1; RdAddress_MEM = 5'd9;
        #3;
        nChecks++;
        if (PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1) begin
            nFails++;
            $display("FAIL branch_mem: got PCWrite=%b Bubble=%b want 0/1", PCWrite, ID_EX_Bubble);
        end
        tick();
        MemRead_MEM = 1'b0; BranchTaken_ID = 1'b1;
        #3;
        nChecks++;
        if (IF_ID_Flush !== 1'b1 || PCWrite !== 1'b1 || StallCycles !== CW'(base + 2)) begin
            nFails++;
            $display("FAIL branch_flush: got flush=%b PCWrite=%b cnt=%0d want 1/1/%0d",
                     IF_ID_Flush, PCWrite, StallCycles, base + 2);
        end
        tick();
        RegWrite_EX = 1'b1; RdAddress_EX = 5'd9;
        #3;
        nChecks++;
        if (IF_ID_Flush !== 1'b0 || ID_EX_Bubble !== 1'b1) begin
            nFails++;
            $display("FAIL stall_over_flush: got flush=%b Bubble=%b want 0/1",
                     IF_ID_Flush, ID_EX_Bubble);
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_mdu();
        int base;
        base = mStallCnt;
        MduStart_ID = 1'b1;
        #3;
        nChecks++;
        if (PCWrite !== 1'b1 || MduBusy !== 1'b0) begin
            nFails++;
            $display("FAIL mdu_accept: got PCWrite=%b busy=%b want 1/0", PCWrite, MduBusy);
        end
        tick();
        MduStart_ID = 1'b0; MduRead_ID = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            #3;
            nChecks++;
            if (MduBusy !== 1'b1 || PCWrite !== 1'b0) begin
                nFails++;
                $display("FAIL mdu_busy_%0d: got busy=%b PCWrite=%b want 1/0", i, MduBusy, PCWrite);
            end
            tick();
        end
        #3;
        nChecks++;
        if (MduBusy !== 1'b0 || PCWrite !== 1'b1 || StallCycles !== CW'(base + LAT)) begin
            nFails++;
            $display("FAIL mdu_release: got busy=%b PCWrite=%b cnt=%0d want 0/1/%0d",
                     MduBusy, PCWrite, StallCycles, base + LAT);
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_random();
        logic [4:0] exp;
        for (int n = 0; n < 1500; n++) begin
            RsAddress_ID   = 5'($urandom_range(0, 3));
            RtAddress_ID   = 5'($urandom_range(0, 3));
            RdAddress_EX   = 5'($urandom_range(0, 3));
            RdAddress_MEM  = 5'($urandom_range(0, 3));
            UsesRt_ID      = 1'($urandom_range(0, 1));
            Branch_ID      = ($urandom_range(0, 3) == 0);
            BranchTaken_ID = 1'($urandom_range(0, 1));
            MduStart_ID    = ($urandom_range(0, 5) == 0);
            MduRead_ID     = ($urandom_range(0, 5) == 0);
            RegWrite_EX    = 1'($urandom_range(0, 1));
            MemRead_EX     = ($urandom_range(0, 3) == 0);
            MemRead_MEM    = ($urandom_range(0, 3) == 0);
            #3;
            exp = refOutputs();
            nChecks++;
            if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MduBusy} !== exp) begin
                nFails++;
                $display("FAIL random_ctl[%0d]: got %b want %b", n,
                         {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MduBusy}, exp);
            end
            nChecks++;
            if (StallCycles !== CW'(mStallCnt)) begin
                nFails++;
                $display("FAIL random_cnt[%0d]: got %0d want %0d", n, StallCycles, mStallCnt);
            end
            tick();
        end
        idleInputs();
        for (int i = 0; i < LAT + 1; i++) tick();
    endtask

    task automatic test_saturation();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; RdAddress_EX = 5'd5; RsAddress_ID = 5'd5;
        for (int i = 0; i < 65536 + 3; i++) tick();
        #3;
        nChecks++;
        if (StallCycles !== 16'hFFFF || mStallCnt != SAT) begin
            nFails++;
            $display("FAIL saturation: got cnt=%0h want ffff", StallCycles);
        end
        idleInputs();
        tick();
    endtask

    task automatic test_reset_mid_mdu();
        MduStart_ID = 1'b1;
        tick();
        MduStart_ID = 1'b0;
        tick();
        #3;
        nChecks++;
        if (MduBusy !== 1'b1) begin
            nFails++;
            $display("FAIL pre_reset_busy: got busy=%b want 1", MduBusy);
        end
        rst_n = 1'b0;
        mHold = 1'b1; mBusyLeft = 0; mStallCnt = 0;
        #1;
        nChecks++;
        if (MduBusy !== 1'b0 || PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1
            || StallCycles !== 16'd0) begin
            nFails++;
            $display("FAIL reset_mid_mdu: got busy=%b PCWrite=%b Bubble=%b cnt=%0d want 0/0/1/0",
                     MduBusy, PCWrite, ID_EX_Bubble, StallCycles);
        end
        tick();
        rst_n = 1'b1;
        #3;
        nChecks++;
        if (PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1 || MduBusy !== 1'b0) begin
            nFails++;
            $display("FAIL rehold: got PCWrite=%b Bubble=%b busy=%b want 0/1/0",
                     PCWrite, ID_EX_Bubble, MduBusy);
        end
        tick();
        #3;
        nChecks++;
        if (PCWrite !== 1'b1 || ID_EX_Bubble !== 1'b0 || StallCycles !== 16'd0) begin
            nFails++;
            $display("FAIL rerun: got PCWrite=%b Bubble=%b cnt=%0d want 1/0/0",
                     PCWrite, ID_EX_Bubble, StallCycles);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_random();
        test_saturation();
        test_reset_mid_mdu();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
